// File: rtl/slab_alloc_arb_pkg.sv
// Shared types for the slab allocator arbiter: response FSM states and requester ID type.
package slab_alloc_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } alloc_fsm_e;

  // ceil(log2(n)) that never collapses to a zero-width field
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_NUM_REQ  = 4;
  localparam int DEFAULT_REQ_ID_W = safe_clog2(DEFAULT_NUM_REQ);

  typedef logic [DEFAULT_REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/slab_rr_arb.sv
// Round-robin picker: first set request at or after ptr, as a one-hot grant plus encoded ID.
module slab_rr_arb
  import slab_alloc_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = safe_clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] id,
  output logic            any
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    id    = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        id         = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/slab_alloc_arbiter.sv
// Shares one slab tracker between NUM_REQ requesters with round-robin alloc and free paths.
// Define SLAB_ALLOC_ARB_QUOTA_EN to cap outstanding slabs per requester at QUOTA.
module slab_alloc_arbiter
  import slab_alloc_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int REQ_ID_W = safe_clog2(NUM_REQ),
  parameter int ADDR_W   = 16,
  parameter int QUOTA    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        src_alloc_req_val,
  output logic [NUM_REQ-1:0]        alloc_src_req_rdy,
  output logic                      alloc_src_resp_val,
  output logic [REQ_ID_W-1:0]       alloc_src_resp_id,
  output logic [ADDR_W-1:0]         alloc_src_resp_addr,
  input  logic                      src_alloc_resp_rdy,
  input  logic [NUM_REQ-1:0]        src_free_req_val,
  input  logic [NUM_REQ*ADDR_W-1:0] src_free_req_addr,
  output logic [NUM_REQ-1:0]        free_src_req_rdy,
  output logic                      arb_trk_consume_val,
  input  logic                      trk_arb_error,
  input  logic [ADDR_W-1:0]         trk_arb_addr,
  output logic                      arb_trk_free_val,
  output logic [ADDR_W-1:0]         arb_trk_free_addr,
  input  logic                      trk_arb_free_rdy
);

  alloc_fsm_e            state;
  logic [REQ_ID_W-1:0]   alloc_ptr;
  logic [REQ_ID_W-1:0]   free_ptr;
  logic [NUM_REQ-1:0]    quota_mask;
  logic [NUM_REQ-1:0]    alloc_grant;
  logic [REQ_ID_W-1:0]   alloc_id;
  logic                  alloc_any;
  logic [NUM_REQ-1:0]    free_grant;
  logic [REQ_ID_W-1:0]   free_id;
  logic                  free_any;
  logic                  can_alloc;
  logic                  alloc_fire;
  logic                  free_fire;
  logic [REQ_ID_W-1:0]   alloc_ptr_next;
  logic [REQ_ID_W-1:0]   free_ptr_next;

  slab_rr_arb #(.N(NUM_REQ), .ID_W(REQ_ID_W)) u_alloc_arb (
    .req   (src_alloc_req_val & ~quota_mask),
    .ptr   (alloc_ptr),
    .grant (alloc_grant),
    .id    (alloc_id),
    .any   (alloc_any)
  );

  slab_rr_arb #(.N(NUM_REQ), .ID_W(REQ_ID_W)) u_free_arb (
    .req   (src_free_req_val),
    .ptr   (free_ptr),
    .grant (free_grant),
    .id    (free_id),
    .any   (free_any)
  );

  // A new grant may overwrite the response register only when it is empty or being drained now
  assign can_alloc  = ~rst & ~trk_arb_error & ((state == EMPTY) | src_alloc_resp_rdy);
  assign alloc_fire = can_alloc & alloc_any;

  assign alloc_src_req_rdy   = can_alloc ? alloc_grant : '0;
  assign arb_trk_consume_val = alloc_fire;
  assign alloc_src_resp_val  = (state == FULL);

  assign arb_trk_free_val  = ~rst & free_any;
  assign arb_trk_free_addr = src_free_req_addr[int'(free_id)*ADDR_W +: ADDR_W];
  assign free_src_req_rdy  = (~rst & trk_arb_free_rdy) ? free_grant : '0;
  assign free_fire         = arb_trk_free_val & trk_arb_free_rdy;

  assign alloc_ptr_next = (alloc_id == REQ_ID_W'(NUM_REQ - 1)) ? '0 : alloc_id + REQ_ID_W'(1);
  assign free_ptr_next  = (free_id  == REQ_ID_W'(NUM_REQ - 1)) ? '0 : free_id  + REQ_ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= EMPTY;
      alloc_src_resp_id   <= '0;
      alloc_src_resp_addr <= '0;
      alloc_ptr           <= '0;
      free_ptr            <= '0;
    end else begin
      if (alloc_fire) begin
        state               <= FULL;
        alloc_src_resp_id   <= alloc_id;
        alloc_src_resp_addr <= trk_arb_addr;
        alloc_ptr           <= alloc_ptr_next;
      end else if (state == FULL && src_alloc_resp_rdy) begin
        state <= EMPTY;
      end
      if (free_fire) begin
        free_ptr <= free_ptr_next;
      end
    end
  end

`ifdef SLAB_ALLOC_ARB_QUOTA_EN
  localparam int CNT_W = $clog2(QUOTA + 1);

  logic [CNT_W-1:0] quota_cnt [NUM_REQ];

  always_comb begin
    quota_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      quota_mask[i] = (quota_cnt[i] == CNT_W'(QUOTA));
    end
  end

  // Grant and accepted free in the same cycle cancel; a stray free never wraps below zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        quota_cnt[i] <= '0;
      end else if (alloc_src_req_rdy[i] && !free_src_req_rdy[i]) begin
        quota_cnt[i] <= quota_cnt[i] + CNT_W'(1);
      end else if (!alloc_src_req_rdy[i] && free_src_req_rdy[i] && quota_cnt[i] != '0) begin
        quota_cnt[i] <= quota_cnt[i] - CNT_W'(1);
      end
    end
  end
`else
  localparam int unused_quota = QUOTA;

  assign quota_mask = '0;
`endif

endmodule

// File: tb/tb_slab_alloc_arbiter.sv
// Self-checking bench for slab_alloc_arbiter: directed scenarios then randomized traffic vs a behavioural model.
module tb_slab_alloc_arbiter;
  import slab_alloc_arb_pkg::*;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int QUOTA = 2;
`ifdef SLAB_ALLOC_ARB_QUOTA_EN
  localparam bit QUOTA_ON = 1'b1;
`else
  localparam bit QUOTA_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_alloc_req_val;
  logic [N-1:0]    alloc_src_req_rdy;
  logic            alloc_src_resp_val;
  req_id_t         alloc_src_resp_id;
  logic [AW-1:0]   alloc_src_resp_addr;
  logic            src_alloc_resp_rdy;
  logic [N-1:0]    src_free_req_val;
  logic [N*AW-1:0] src_free_req_addr;
  logic [N-1:0]    free_src_req_rdy;
  logic            arb_trk_consume_val;
  logic            trk_arb_error;
  logic [AW-1:0]   trk_arb_addr;
  logic            arb_trk_free_val;
  logic [AW-1:0]   arb_trk_free_addr;
  logic            trk_arb_free_rdy;

  int tests  = 0;
  int failed = 0;

  // Behavioural model: pending response, RR pointers, outstanding counts, tracker slab counter
  bit m_pending;
  int m_rid, m_raddr, m_aptr, m_fptr, trk_count;
  int m_cnt [N];

  always #5 clk = ~clk;

  slab_alloc_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .QUOTA(QUOTA)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .src_alloc_req_val   (src_alloc_req_val),
    .alloc_src_req_rdy   (alloc_src_req_rdy),
    .alloc_src_resp_val  (alloc_src_resp_val),
    .alloc_src_resp_id   (alloc_src_resp_id),
    .alloc_src_resp_addr (alloc_src_resp_addr),
    .src_alloc_resp_rdy  (src_alloc_resp_rdy),
    .src_free_req_val    (src_free_req_val),
    .src_free_req_addr   (src_free_req_addr),
    .free_src_req_rdy    (free_src_req_rdy),
    .arb_trk_consume_val (arb_trk_consume_val),
    .trk_arb_error       (trk_arb_error),
    .trk_arb_addr        (trk_arb_addr),
    .arb_trk_free_val    (arb_trk_free_val),
    .arb_trk_free_addr   (arb_trk_free_addr),
    .trk_arb_free_rdy    (trk_arb_free_rdy)
  );

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_rid     = 0;
    m_raddr   = 0;
    m_aptr    = 0;
    m_fptr    = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock cycle: drive inputs, compare every output with the model, then advance the model
  task automatic apply_stimulus(input logic r, input logic [N-1:0] av, input logic rr, input logic er,
                                input logic [N-1:0] fv, input logic [N*AW-1:0] fa, input logic fr);
    int aw, fw, c;
    bit can;
    logic [N-1:0] exp_ardy, exp_frdy;
    @(negedge clk);
    rst                = r;
    src_alloc_req_val  = av;
    src_alloc_resp_rdy = rr;
    trk_arb_error      = er;
    src_free_req_val   = fv;
    src_free_req_addr  = fa;
    trk_arb_free_rdy   = fr;
    trk_arb_addr       = AW'(trk_count * 64);
    #1;
    check_output("resp_val", 64'(alloc_src_resp_val), 64'(m_pending));
    check_output("resp_id", 64'(alloc_src_resp_id), 64'(m_rid));
    check_output("resp_addr", 64'(alloc_src_resp_addr), 64'(m_raddr));

    can = !r && !er && (!m_pending || rr);
    aw  = -1;
    if (can) begin
      for (int k = 0; k < N; k++) begin
        c = (m_aptr + k) % N;
        if (aw < 0 && av[c] && (!QUOTA_ON || m_cnt[c] < QUOTA)) aw = c;
      end
    end
    fw = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        c = (m_fptr + k) % N;
        if (fw < 0 && fv[c]) fw = c;
      end
    end
    exp_ardy = (aw >= 0) ? N'(1 << aw) : '0;
    exp_frdy = (fw >= 0 && fr) ? N'(1 << fw) : '0;

    check_output("alloc_rdy", 64'(alloc_src_req_rdy), 64'(exp_ardy));
    check_output("consume_val", 64'(arb_trk_consume_val), 64'(aw >= 0));
    check_output("free_val", 64'(arb_trk_free_val), 64'(fw >= 0));
    check_output("free_rdy", 64'(free_src_req_rdy), 64'(exp_frdy));
    if (fw >= 0) check_output("free_addr", 64'(arb_trk_free_addr), 64'(fa[fw*AW +: AW]));

    if (r) begin
      model_reset();
    end else begin
      if (aw >= 0) begin
        m_pending = 1'b1;
        m_rid     = aw;
        m_raddr   = (trk_count * 64) % (1 << AW);
        m_aptr    = (aw + 1) % N;
        trk_count++;
      end else if (m_pending && rr) begin
        m_pending = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (i == aw && !(i == fw && fr)) m_cnt[i]++;
        else if (i != aw && i == fw && fr && m_cnt[i] > 0) m_cnt[i]--;
      end
      if (fw >= 0 && fr) m_fptr = (fw + 1) % N;
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    trk_count = 0;
  endtask

  initial begin
    logic [N*AW-1:0] fa;
    rst = 1'b1;
    src_alloc_req_val  = '0;
    src_alloc_resp_rdy = 1'b0;
    trk_arb_error      = 1'b0;
    src_free_req_val   = '0;
    src_free_req_addr  = '0;
    trk_arb_free_rdy   = 1'b0;
    trk_arb_addr       = '0;
    trk_count          = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Streaming grants to all four requesters with the response always consumed
    do_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 4'b1111, 1'b1, 1'b0, '0, '0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, '0, '0, 1'b0);
    check_output("stream_last_id", 64'(alloc_src_resp_id), 64'd0);
    check_output("stream_last_addr", 64'(alloc_src_resp_addr), 64'd256);

    // Back-pressured response holds id and addr
    do_reset();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 4'b0100, 1'b0, 1'b0, '0, '0, 1'b0);
    check_output("held_id", 64'(alloc_src_resp_id), 64'd2);
    apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, '0, '0, 1'b0);

    // Tracker error blocks grants; pointer preserved
    do_reset();
    apply_stimulus(1'b0, 4'b0001, 1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'b1111, 1'b1, 1'b1, '0, '0, 1'b0);
    apply_stimulus(1'b0, 4'b1111, 1'b1, 1'b0, '0, '0, 1'b0);
    check_output("err_resume_rdy", 64'(alloc_src_req_rdy), 64'b0010);

    // Free path with a toggling tracker ready
    do_reset();
    fa = '0;
    fa[1*AW +: AW] = 16'h0040;
    fa[3*AW +: AW] = 16'h00C0;
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 4'b1010, fa, 1'b0);
    check_output("free_first_addr", 64'(arb_trk_free_addr), 64'h40);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 4'b1010, fa, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 4'b1000, fa, 1'b0);
    check_output("free_second_addr", 64'(arb_trk_free_addr), 64'hC0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0, 4'b1000, fa, 1'b1);

    // Same requester allocates and frees in one cycle
    do_reset();
    fa = '0;
    fa[1*AW +: AW] = 16'h0080;
    apply_stimulus(1'b0, 4'b0010, 1'b1, 1'b0, 4'b0010, fa, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, fa, 1'b0);

    // Quota: requester 0 allocates until masked, then a free re-enables it
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 4'b0001, 1'b1, 1'b0, '0, '0, 1'b0);
    fa = '0;
    apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0001, fa, 1'b1);
    apply_stimulus(1'b0, 4'b0001, 1'b1, 1'b0, '0, '0, 1'b0);

    // Randomized traffic including occasional mid-operation resets
    for (int i = 0; i < 600; i++) begin
      fa = {$urandom, $urandom};
      apply_stimulus(($urandom_range(0, 59) == 0), N'($urandom), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 7) == 0), N'($urandom), fa, $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
